// File: rtl/shift_frame_arbiter.sv
// Round-robin frame arbiter in front of a shared block-serial right shifter.
// Streams one requester's whole frame to the shifter and tags the returned result blocks.
module shift_frame_arbiter #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned NUM_BLOCKS    = 256,
    parameter int unsigned SHIFT_BY      = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     req0_valid_in,
    input  logic [REGISTER_SIZE-1:0] req0_block_in,
    output logic                     req0_ready_out,
    input  logic                     req1_valid_in,
    input  logic [REGISTER_SIZE-1:0] req1_block_in,
    output logic                     req1_ready_out,
    output logic                     shift_rst_out,
    output logic                     shift_valid_out,
    output logic [REGISTER_SIZE-1:0] shift_block_out,
    input  logic                     shift_valid_in,
    input  logic [REGISTER_SIZE-1:0] shift_block_in,
    output logic                     res_valid_out,
    output logic [REGISTER_SIZE-1:0] res_block_out,
    output logic                     res_id_out,
    output logic                     res_last_out,
    output logic                     busy_out,
    output logic                     err_out
);

    localparam int unsigned IGNORE     = SHIFT_BY / REGISTER_SIZE;
    localparam int unsigned OUT_BLOCKS = NUM_BLOCKS - IGNORE;
    localparam int unsigned CntW       = $clog2(NUM_BLOCKS) + 1;

    localparam logic [CntW-1:0] NumBlocksC = CntW'(NUM_BLOCKS);
    localparam logic [CntW-1:0] OutBlocksC = CntW'(OUT_BLOCKS);
    localparam logic [CntW-1:0] OneC       = CntW'(1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [CntW-1:0]          in_cnt_q, in_cnt_d;
    logic [CntW-1:0]          out_cnt_q, out_cnt_d;
    logic                     shift_rst_q;
    logic                     res_valid_q, res_valid_d;
    logic [REGISTER_SIZE-1:0] res_block_q, res_block_d;
    logic                     res_id_q, res_id_d;
    logic                     res_last_q, res_last_d;
    logic                     err_q, err_d;

    logic                     streaming;
    logic                     sel_valid;
    logic [REGISTER_SIZE-1:0] sel_block;
    logic                     accept;

    // last_grant_q doubles as the current owner while a frame is in flight.
    assign streaming       = (state_q == StStream);
    assign sel_valid       = last_grant_q ? req1_valid_in : req0_valid_in;
    assign sel_block       = last_grant_q ? req1_block_in : req0_block_in;
    assign req0_ready_out  = streaming & ~last_grant_q;
    assign req1_ready_out  = streaming & last_grant_q;
    assign accept          = streaming & sel_valid;
    assign shift_valid_out = accept;
    assign shift_block_out = sel_block;

    assign shift_rst_out = shift_rst_q;
    assign res_valid_out = res_valid_q;
    assign res_block_out = res_block_q;
    assign res_id_out    = res_id_q;
    assign res_last_out  = res_last_q;
    assign busy_out      = (state_q != StIdle);
    assign err_out       = err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        res_valid_d  = 1'b0;
        res_block_d  = res_block_q;
        res_id_d     = res_id_q;
        res_last_d   = res_last_q;
        err_d        = err_q;

        // Results outside a frame or beyond the expected count are dropped and flagged.
        if (shift_valid_in) begin
            if ((state_q == StIdle) || (out_cnt_q == OutBlocksC)) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d   = out_cnt_q + OneC;
                res_valid_d = 1'b1;
                res_block_d = shift_block_in;
                res_id_d    = last_grant_q;
                res_last_d  = ((out_cnt_q + OneC) == OutBlocksC);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!shift_rst_q && (req0_valid_in || req1_valid_in)) begin
                    if (req0_valid_in && req1_valid_in) begin
                        last_grant_d = ~last_grant_q;
                    end else begin
                        last_grant_d = req1_valid_in;
                    end
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + OneC;
                    if ((in_cnt_q + OneC) == NumBlocksC) begin
                        state_d = (out_cnt_d == OutBlocksC) ? StIdle : StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_cnt_q == OutBlocksC) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            shift_rst_q  <= 1'b1;
            res_valid_q  <= 1'b0;
            res_block_q  <= '0;
            res_id_q     <= 1'b0;
            res_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            shift_rst_q  <= 1'b0;
            res_valid_q  <= res_valid_d;
            res_block_q  <= res_block_d;
            res_id_q     <= res_id_d;
            res_last_q   <= res_last_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Directed bench for shift_frame_arbiter with a behavioural shifter (0 or 2 cycle latency)
// and a result scoreboard.
module tb_shift_frame_arbiter;

    localparam int RS  = 32;
    localparam int NB  = 8;
    localparam int SB  = 128;
    localparam int IGN = SB / RS;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          req0_valid_in = 1'b0;
    logic [RS-1:0] req0_block_in = '0;
    logic          req0_ready_out;
    logic          req1_valid_in = 1'b0;
    logic [RS-1:0] req1_block_in = '0;
    logic          req1_ready_out;
    logic          shift_rst_out;
    logic          shift_valid_out;
    logic [RS-1:0] shift_block_out;
    logic          shift_valid_in;
    logic [RS-1:0] shift_block_in;
    logic          res_valid_out;
    logic [RS-1:0] res_block_out;
    logic          res_id_out;
    logic          res_last_out;
    logic          busy_out;
    logic          err_out;

    int vectors = 0;
    int miscompares = 0;

    shift_frame_arbiter #(
        .REGISTER_SIZE(RS),
        .NUM_BLOCKS   (NB),
        .SHIFT_BY     (SB)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req0_valid_in  (req0_valid_in),
        .req0_block_in  (req0_block_in),
        .req0_ready_out (req0_ready_out),
        .req1_valid_in  (req1_valid_in),
        .req1_block_in  (req1_block_in),
        .req1_ready_out (req1_ready_out),
        .shift_rst_out  (shift_rst_out),
        .shift_valid_out(shift_valid_out),
        .shift_block_out(shift_block_out),
        .shift_valid_in (shift_valid_in),
        .shift_block_in (shift_block_in),
        .res_valid_out  (res_valid_out),
        .res_block_out  (res_block_out),
        .res_id_out     (res_id_out),
        .res_last_out   (res_last_out),
        .busy_out       (busy_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    // Shifter model: drops the first IGN blocks of each frame, passes the rest through.
    int            lat = 0;
    logic          inject = 1'b0;
    int            sh_cnt = 0;
    logic          p0_v = 1'b0;
    logic          p1_v = 1'b0;
    logic [RS-1:0] p0_d = '0;
    logic [RS-1:0] p1_d = '0;
    logic          keep;

    assign keep = shift_valid_out && ((sh_cnt % NB) >= IGN);

    always @(posedge clk_in) begin
        if (shift_rst_out) begin
            sh_cnt <= 0;
            p0_v   <= 1'b0;
            p1_v   <= 1'b0;
        end else begin
            if (shift_valid_out) sh_cnt <= sh_cnt + 1;
            p0_v <= keep && (lat == 2);
            p0_d <= shift_block_out;
            p1_v <= p0_v;
            p1_d <= p0_d;
        end
    end

    assign shift_valid_in = ((lat == 0) ? keep : p1_v) | inject;
    assign shift_block_in = (lat == 0) ? shift_block_out : p1_d;

    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];

    always @(negedge clk_in) begin
        if (res_valid_out === 1'b1) got_q.push_back({res_id_out, res_last_out, res_block_out});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [RS-1:0] d);
        if (id) begin
            req1_valid_in = v;
            req1_block_in = d;
        end else begin
            req0_valid_in = v;
            req0_block_in = d;
        end
    endtask

    task automatic push_exp(input logic id, input logic [RS-1:0] base);
        logic [RS-1:0] d;
        for (int k = IGN; k < NB; k++) begin
            d = base + RS'(k);
            exp_q.push_back({id, (k == NB - 1) ? 1'b1 : 1'b0, d});
        end
    endtask

    // Sends nblk blocks base+i; waits counts idle negedges before the first accept.
    task automatic send_frame(input logic id, input logic [RS-1:0] base, input int nblk,
                              input int stall_after, output int waits);
        logic [RS-1:0] d;
        logic          rdy;
        logic          ordy;
        bit            ok;
        waits = 0;
        for (int i = 0; i < nblk; i++) begin
            d = base + RS'(i);
            drive(id, 1'b1, d);
            ok   = 1'b0;
            ordy = 1'b0;
            for (int c = 0; c < 64; c++) begin
                @(negedge clk_in);
                rdy  = id ? req1_ready_out : req0_ready_out;
                ordy = id ? req0_ready_out : req1_ready_out;
                if (rdy === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                if (i == 0) waits++;
            end
            if (!ok) begin
                chk("grant_timeout", 64'd0, 64'd1);
                drive(id, 1'b0, '0);
                return;
            end
            chk("other_ready", ordy, 0);
            chk("shift_valid", shift_valid_out, 1);
            chk("shift_block", shift_block_out, d);
            @(posedge clk_in);
            #1;
            if (i == stall_after) begin
                drive(id, 1'b0, d);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk_in);
                    chk("stall_valid", shift_valid_out, 0);
                    chk("stall_grant", id ? req1_ready_out : req0_ready_out, 1);
                end
                @(posedge clk_in);
                #1;
            end
        end
        drive(id, 1'b0, '0);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk_in);
            if (busy_out === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("busy_fall", done, 1);
        @(negedge clk_in);
        #1;
    endtask

    task automatic check_results();
        logic [33:0] g;
        logic [33:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                chk("res_missing", 64'd0, {30'd0, e} | 64'h1_0000_0000_0);
            end else begin
                g = got_q.pop_front();
                chk("res", g, e);
            end
        end
        chk("res_extra", got_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_res_valid", res_valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_shift_rst", shift_rst_out, 1);
        chk("rst_ready", {req0_ready_out, req1_ready_out}, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("shift_rst_hold", shift_rst_out, 1);
        @(negedge clk_in);
        chk("shift_rst_drop", shift_rst_out, 0);
        chk("no_grant_in_rst_cycle", busy_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit found;

        // Single requester frame right after reset.
        drive(1'b0, 1'b1, 32'hA000_0000);
        do_reset();
        push_exp(1'b0, 32'hA000_0000);
        send_frame(1'b0, 32'hA000_0000, NB, -1, w);
        wait_idle();
        check_results();

        // Both requesting: req0 first, then alternation; last frame stalls.
        drive(1'b0, 1'b1, 32'hB000_0000);
        drive(1'b1, 1'b1, 32'hC000_0000);
        do_reset();
        push_exp(1'b0, 32'hB000_0000);
        send_frame(1'b0, 32'hB000_0000, NB, -1, w);
        drive(1'b0, 1'b1, 32'hD000_0000);
        push_exp(1'b1, 32'hC000_0000);
        send_frame(1'b1, 32'hC000_0000, NB, -1, w);
        chk("gap_req1", w, 1);
        drive(1'b1, 1'b1, 32'hE000_0000);
        push_exp(1'b0, 32'hD000_0000);
        send_frame(1'b0, 32'hD000_0000, NB, -1, w);
        chk("gap_req0", w, 1);
        push_exp(1'b1, 32'hE000_0000);
        send_frame(1'b1, 32'hE000_0000, NB, 2, w);
        wait_idle();
        check_results();

        // Two-cycle shifter latency, then a surplus result while draining.
        lat = 2;
        push_exp(1'b0, 32'hF000_0000);
        send_frame(1'b0, 32'hF000_0000, NB, -1, w);
        found = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (res_last_out === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        chk("lat2_last_seen", found, 1);
        chk("lat2_drain_busy", busy_out, 1);
        chk("lat2_err_clean", err_out, 0);
        inject = 1'b1;
        @(posedge clk_in);
        #1;
        inject = 1'b0;
        chk("surplus_err", err_out, 1);
        chk("surplus_idle", busy_out, 0);
        @(negedge clk_in);
        chk("surplus_no_res", res_valid_out, 0);
        lat = 0;
        repeat (2) @(negedge clk_in);
        #1;
        check_results();

        // Reset after block 5 of a frame.
        exp_q.push_back({1'b0, 1'b0, 32'h1200_0004});
        send_frame(1'b0, 32'h1200_0000, 6, -1, w);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_busy", busy_out, 0);
        chk("midrst_res_valid", res_valid_out, 0);
        chk("midrst_res_block", res_block_out, 0);
        chk("midrst_err", err_out, 0);
        chk("midrst_shift_rst", shift_rst_out, 1);
        chk("midrst_ready", req0_ready_out, 0);
        check_results();
        do_reset();
        push_exp(1'b1, 32'h3400_0000);
        send_frame(1'b1, 32'h3400_0000, NB, -1, w);
        wait_idle();
        check_results();
        chk("fresh_err", err_out, 0);

        // Shifter result while idle.
        @(posedge clk_in);
        #1;
        inject = 1'b1;
        @(posedge clk_in);
        #1;
        inject = 1'b0;
        chk("idle_err", err_out, 1);
        repeat (3) @(negedge clk_in);
        chk("idle_err_sticky", err_out, 1);
        chk("idle_no_res", got_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_frame_arbiter.md
Name: shift_frame_arbiter

Overview:
- Shares one block-serial right-shift datapath between two requesters, whole frames at a time.
- A frame is NUM_BLOCKS blocks, LSB block first.
- Grants round-robin, feeds the granted requester's blocks to the shifter, and counts shifter results until the frame completes.
- Returns results tagged with the owner id. Sits between the modular-arithmetic producers and the shared shifter.

Parameters:
- REGISTER_SIZE, 32, width of one block in bits.
- NUM_BLOCKS, 256, blocks per input frame.
- SHIFT_BY, 4096, shift amount in bits; a power of 2 and a multiple of REGISTER_SIZE.
- Derived: IGNORE = SHIFT_BY/REGISTER_SIZE; OUT_BLOCKS = NUM_BLOCKS-IGNORE (at least 1).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- req0_valid_in  in  1  requester 0 block valid
- req0_block_in  in  REGISTER_SIZE  requester 0 block
- req0_ready_out  out  1  requester 0 block accepted this cycle when valid&ready
- req1_valid_in / req1_block_in / req1_ready_out  same meanings for requester 1
- shift_rst_out  out  1  active-high synchronous reset to the shifter
- shift_valid_out  out  1  block valid to the shifter
- shift_block_out  out  REGISTER_SIZE  block to the shifter
- shift_valid_in  in  1  shifter result valid
- shift_block_in  in  REGISTER_SIZE  shifter result block
- res_valid_out  out  1  result block valid (registered)
- res_block_out  out  REGISTER_SIZE  result block
- res_id_out  out  1  owner of the result (0/1)
- res_last_out  out  1  final result block of the frame
- busy_out  out  1  a frame is granted and not yet complete
- err_out  out  1  sticky: shifter result arrived outside a frame, or too many results

Behaviour:
- Reset (rst_n_in low, asynchronous): state=IDLE, last_grant=1 (so requester 0 wins first).
  - Counters, res_* and busy_out go to 0; err_out goes to 0.
  - shift_rst_out goes to 1 and is held for exactly one clock after reset release.
  - No requester is granted during that cycle.
- Counters: in_cnt and out_cnt are $clog2(NUM_BLOCKS)+1 bits wide and unsigned.
- State IDLE:
  - req*_ready_out=0.
  - If exactly one reqX_valid_in is high, grant X.
  - If both are high, grant !last_grant.
  - On a grant: update last_grant, clear the counters, move to STREAM on the next cycle.
  - The grant is decided in IDLE only; a request never goes through in the same cycle it is made.
- State STREAM:
  - reqG_ready_out=1 for the granted requester only; the other ready stays 0.
  - shift_valid_out = reqG_valid_in & reqG_ready_out; shift_block_out = reqG_block_in. Both are combinational.
  - Each accepted block increments in_cnt.
  - When the NUM_BLOCKS-th block is accepted, deassert ready from the next cycle and go to DRAIN.
  - If out_cnt also reaches OUT_BLOCKS in that same cycle, go to IDLE instead.
- State DRAIN:
  - ready=0, shift_valid_out=0.
  - Wait until out_cnt reaches OUT_BLOCKS, then go to IDLE.
  - Supports shifters with 0..N cycles of latency.
- Result path (any state, in flight):
  - Each shift_valid_in increments out_cnt.
  - On the next cycle: res_valid_out=1, res_block_out=shift_block_in, res_id_out=granted id.
  - res_last_out=1 when this result is number OUT_BLOCKS.
  - When no result is valid, res_valid_out=0 and the other res_* hold their values.
- busy_out=1 in STREAM and DRAIN.
- Minimum gap between frames is one IDLE cycle. Back-to-back requests alternate between requesters.
- Errors:
  - shift_valid_in while in IDLE sets err_out; the data is dropped and no res_valid_out is produced.
  - shift_valid_in after out_cnt == OUT_BLOCKS sets err_out; the data is dropped.
  - err_out clears only on reset.
- A requester dropping valid mid-frame is a stall, not an abort; the grant holds until all NUM_BLOCKS blocks are taken.
- Reset mid-frame: everything returns to its reset values at once, and shift_rst_out clears the shifter's partial frame.

Test Plan (REGISTER_SIZE=32, NUM_BLOCKS=8, SHIFT_BY=128, so IGNORE=4 and OUT_BLOCKS=4; zero-latency shifter model):
- Reset release -> shift_rst_out=1 for exactly 1 cycle. Then req0 sends blocks 0..7 -> req0_ready_out high for 8 accepted beats. res_valid_out 4 times with blocks 4,5,6,7, res_id_out=0, res_last_out only on block 7. busy_out falls after the frame.
- req0 and req1 both valid in IDLE after reset -> req0 granted first; req1 granted in the first IDLE cycle after req0's frame. Then both requesting again -> req0 granted (alternation). req1_ready_out is never high during req0's frame.
- Stall: req1 drops valid for 3 cycles after block 2 -> no shift_valid_out during the gap, grant held. Result is still 4 blocks, tagged id 1.
- Shifter model with 2-cycle latency -> DRAIN lasts until the 4th result. res_last_out on the 4th result, then IDLE; err_out stays 0.
- shift_valid_in pulsed in IDLE, and a 5th result injected in DRAIN -> err_out=1 and sticky; no res_valid_out for either pulse.
- rst_n_in pulled low after block 5 of a frame -> outputs go to reset values immediately. After release: shift_rst_out pulse, then a fresh frame completes correctly with 4 results.
